// File: rtl/strash_pkg.sv
`default_nettype none
// ============================================================================
// Module   : strash_pkg
// Purpose  : Shared types and helpers for the structural-hash lookup unit:
//            FSM state encoding, hash-table entry layout, hash multiplier and
//            the trivial-AND simplification function.
// Revision : 1.0 - initial release
// ============================================================================
package strash_pkg;

    // Widest literal the entry layout can hold; LIT_W of the unit must not exceed it.
    localparam int          C_LIT_W_MAX = 16;
    localparam logic [31:0] C_HASH_MULT = 32'h9E3779B1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HASH   = 3'd1,
        ST_PROBE  = 3'd2,
        ST_INSERT = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    typedef struct packed {
        logic                   valid;
        logic [C_LIT_W_MAX-1:0] l0;
        logic [C_LIT_W_MAX-1:0] l1;
        logic [C_LIT_W_MAX-1:0] id;
    } entry_t;

    // Returns {is_trivial, lit} for a canonical pair (l0 <= l1). Order of
    // tests matters: x&x and x&~x must be caught before the constant checks.
    function automatic logic [C_LIT_W_MAX:0] strash_trivial(
        input logic [C_LIT_W_MAX-1:0] l0,
        input logic [C_LIT_W_MAX-1:0] l1
    );
        logic [C_LIT_W_MAX:0] r;
        r = '0;
        if (l0 == l1)
            r = {1'b1, l0};
        else if (l0 == (l1 ^ C_LIT_W_MAX'(1)))
            r = {1'b1, {C_LIT_W_MAX{1'b0}}};
        else if (l0 == '0)
            r = {1'b1, {C_LIT_W_MAX{1'b0}}};
        else if (l0 == C_LIT_W_MAX'(1))
            r = {1'b1, l1};
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/strash_hash.sv
`default_nettype none
// ============================================================================
// Module   : strash_hash
// Purpose  : Combinational hash of a canonical fanin pair into a table index:
//            idx = (l0 * C_HASH_MULT ^ l1) truncated to DEPTH_LOG2 bits.
// Ports    : l0, l1  - canonical fanin literals (LIT_W)
//            idx     - home slot in the hash table (DEPTH_LOG2)
// Revision : 1.0 - initial release
// ============================================================================
module strash_hash
    import strash_pkg::*;
#(
    parameter int LIT_W      = 16,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic [LIT_W-1:0]      l0,
    input  logic [LIT_W-1:0]      l1,
    output logic [DEPTH_LOG2-1:0] idx
);

    logic [31:0] w_prod;

    assign w_prod = 32'(l0) * C_HASH_MULT;
    assign idx    = DEPTH_LOG2'(w_prod ^ 32'(l1));

endmodule
`default_nettype wire

// File: rtl/strash_lookup_unit.sv
`default_nettype none
// ============================================================================
// Module   : strash_lookup_unit
// Purpose  : Structural-hash engine for AIG construction. Accepts an AND
//            request (two fanin literals), returns the literal of an existing
//            equivalent node or allocates a new node ID. Linear-probing hash
//            table, one probe per cycle.
// Ports    : clk, rst (sync, active-high), clear (sync flush)
//            req_valid/req_ready, req_lit0, req_lit1   - request side
//            rsp_valid/rsp_ready, rsp_lit, rsp_hit,
//            rsp_new, rsp_full                          - response side
//            stat_hits, stat_new, stat_probes           - only with
//                                                         STRASH_STATS_EN
// Config   : define STRASH_STATS_EN to add saturating 32-bit statistics.
// Revision : 1.0 - initial release
// ============================================================================
module strash_lookup_unit
    import strash_pkg::*;
#(
    parameter int LIT_W      = 16,
    parameter int DEPTH_LOG2 = 6,
    parameter int NUM_PI     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [LIT_W-1:0] req_lit0,
    input  logic [LIT_W-1:0] req_lit1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [LIT_W-1:0] rsp_lit,
    output logic             rsp_hit,
    output logic             rsp_new,
    output logic             rsp_full
`ifdef STRASH_STATS_EN
    ,
    output logic [31:0]      stat_hits,
    output logic [31:0]      stat_new,
    output logic [31:0]      stat_probes
`endif
);

    localparam int                c_entries    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_probe_last = (DEPTH_LOG2+1)'(c_entries - 1);
    localparam logic [LIT_W-1:0]  c_max_id     = LIT_W'((1 << (LIT_W-1)) - 1);
    localparam logic [LIT_W-1:0]  c_first_id   = LIT_W'(NUM_PI + 1);

    state_t                r_state;
    logic [LIT_W-1:0]      r_l0;
    logic [LIT_W-1:0]      r_l1;
    logic [LIT_W-1:0]      r_next_id;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [DEPTH_LOG2:0]   r_probes;
    logic [c_entries-1:0]  r_valid;
    entry_t                r_table [c_entries];

    logic                  r_rsp_valid;
    logic [LIT_W-1:0]      r_rsp_lit;
    logic                  r_rsp_hit;
    logic                  r_rsp_new;
    logic                  r_rsp_full;

    logic [LIT_W-1:0]       w_a;
    logic [LIT_W-1:0]       w_b;
    logic [C_LIT_W_MAX:0]   w_triv;
    logic [DEPTH_LOG2-1:0]  w_hash_idx;
    entry_t                 w_entry;
    logic                   w_slot_valid;
    logic                   w_key_match;
    logic                   w_id_ok;
    logic                   w_do_write;

    // Canonical order makes (a,b) and (b,a) share one table entry.
    assign w_a    = (req_lit0 < req_lit1) ? req_lit0 : req_lit1;
    assign w_b    = (req_lit0 < req_lit1) ? req_lit1 : req_lit0;
    assign w_triv = strash_trivial(C_LIT_W_MAX'(w_a), C_LIT_W_MAX'(w_b));

    strash_hash #(
        .LIT_W      (LIT_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_hash (
        .l0  (r_l0),
        .l1  (r_l1),
        .idx (w_hash_idx)
    );

    // Slot validity lives in r_valid so that clear can flush it in one cycle;
    // the entry payload itself is never reset.
    assign w_entry      = r_table[r_idx];
    assign w_slot_valid = r_valid[r_idx] && w_entry.valid;
    assign w_key_match  = (w_entry.l0 == C_LIT_W_MAX'(r_l0)) &&
                          (w_entry.l1 == C_LIT_W_MAX'(r_l1));
    assign w_id_ok      = (r_next_id <= c_max_id);
    assign w_do_write   = (r_state == ST_INSERT) && w_id_ok && !rst && !clear;

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_lit   = r_rsp_lit;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_new   = r_rsp_new;
    assign rsp_full  = r_rsp_full;

    always_ff @(posedge clk) begin
        if (w_do_write)
            r_table[r_idx] <= '{valid: 1'b1,
                                l0:    C_LIT_W_MAX'(r_l0),
                                l1:    C_LIT_W_MAX'(r_l1),
                                id:    C_LIT_W_MAX'(r_next_id)};
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state     <= ST_IDLE;
            r_valid     <= '0;
            r_next_id   <= c_first_id;
            r_l0        <= '0;
            r_l1        <= '0;
            r_idx       <= '0;
            r_probes    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_lit   <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_new   <= 1'b0;
            r_rsp_full  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_l0 <= w_a;
                        r_l1 <= w_b;
                        if (w_triv[C_LIT_W_MAX]) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_lit   <= w_triv[LIT_W-1:0];
                        end else begin
                            r_state <= ST_HASH;
                        end
                    end
                end
                ST_HASH: begin
                    r_idx    <= w_hash_idx;
                    r_probes <= '0;
                    r_state  <= ST_PROBE;
                end
                ST_PROBE: begin
                    if (w_slot_valid && w_key_match) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_lit   <= LIT_W'({w_entry.id, 1'b0});
                        r_rsp_hit   <= 1'b1;
                    end else if (!w_slot_valid) begin
                        r_state <= ST_INSERT;
                    end else if (r_probes == c_probe_last) begin
                        // Every slot visited and occupied by other keys.
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_lit   <= '0;
                        r_rsp_full  <= 1'b1;
                    end else begin
                        r_idx    <= r_idx + 1'b1;
                        r_probes <= r_probes + 1'b1;
                    end
                end
                ST_INSERT: begin
                    r_state     <= ST_RESP;
                    r_rsp_valid <= 1'b1;
                    if (w_id_ok) begin
                        r_valid[r_idx] <= 1'b1;
                        r_rsp_lit      <= LIT_W'({r_next_id, 1'b0});
                        r_rsp_new      <= 1'b1;
                        r_next_id      <= r_next_id + 1'b1;
                    end else begin
                        r_rsp_lit  <= '0;
                        r_rsp_full <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_lit   <= '0;
                        r_rsp_hit   <= 1'b0;
                        r_rsp_new   <= 1'b0;
                        r_rsp_full  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef STRASH_STATS_EN
    logic [31:0] r_stat_hits;
    logic [31:0] r_stat_new;
    logic [31:0] r_stat_probes;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_stat_hits   <= '0;
            r_stat_new    <= '0;
            r_stat_probes <= '0;
        end else begin
            if (r_rsp_valid && rsp_ready && r_rsp_hit && (r_stat_hits != '1))
                r_stat_hits <= r_stat_hits + 1'b1;
            if (r_rsp_valid && rsp_ready && r_rsp_new && (r_stat_new != '1))
                r_stat_new <= r_stat_new + 1'b1;
            if ((r_state == ST_PROBE) && (r_stat_probes != '1))
                r_stat_probes <= r_stat_probes + 1'b1;
        end
    end

    assign stat_hits   = r_stat_hits;
    assign stat_new    = r_stat_new;
    assign stat_probes = r_stat_probes;
`endif

endmodule
`default_nettype wire

// File: tb/tb_strash_lookup_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_strash_lookup_unit
// Purpose  : Self-checking bench for strash_lookup_unit. Two instances share
//            the request/response stimulus: a 64-entry table and a 4-entry
//            table (for table exhaustion). A reference model holds the hash
//            table as a slot array and derives result and latency per request.
// Revision : 1.0 - initial release
// ============================================================================
module tb_strash_lookup_unit;

    logic        clk = 1'b0;
    logic        rst, clear, req_valid, rsp_ready;
    logic [15:0] req_lit0, req_lit1;
    int          sel;

    logic        rq0, rv0, h0, n0, f0, rq1, rv1, h1, n1, f1;
    logic [15:0] lo0, lo1;
    logic        m_rq, m_rv, m_h, m_n, m_f;
    logic [15:0] m_lit;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

`ifdef STRASH_STATS_EN
    logic [31:0] s0h, s0n, s0p, s1h, s1n, s1p;
`endif

    strash_lookup_unit u_dut0 (
        .clk(clk), .rst(rst), .clear(clear),
        .req_valid(req_valid && (sel == 0)), .req_ready(rq0),
        .req_lit0(req_lit0), .req_lit1(req_lit1),
        .rsp_valid(rv0), .rsp_ready(rsp_ready && (sel == 0)),
        .rsp_lit(lo0), .rsp_hit(h0), .rsp_new(n0), .rsp_full(f0)
`ifdef STRASH_STATS_EN
        , .stat_hits(s0h), .stat_new(s0n), .stat_probes(s0p)
`endif
    );

    strash_lookup_unit #(.DEPTH_LOG2(2)) u_dut1 (
        .clk(clk), .rst(rst), .clear(clear),
        .req_valid(req_valid && (sel == 1)), .req_ready(rq1),
        .req_lit0(req_lit0), .req_lit1(req_lit1),
        .rsp_valid(rv1), .rsp_ready(rsp_ready && (sel == 1)),
        .rsp_lit(lo1), .rsp_hit(h1), .rsp_new(n1), .rsp_full(f1)
`ifdef STRASH_STATS_EN
        , .stat_hits(s1h), .stat_new(s1n), .stat_probes(s1p)
`endif
    );

    assign m_rq  = (sel == 1) ? rq1 : rq0;
    assign m_rv  = (sel == 1) ? rv1 : rv0;
    assign m_lit = (sel == 1) ? lo1 : lo0;
    assign m_h   = (sel == 1) ? h1  : h0;
    assign m_n   = (sel == 1) ? n1  : n0;
    assign m_f   = (sel == 1) ? f1  : f0;

    // ---------------- reference model ----------------
    int ms_key [2][64];
    int ms_id  [2][64];
    bit ms_v   [2][64];
    int m_next [2];
    int m_size [2] = '{64, 4};

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            m_next[s] = 4;
            for (int i = 0; i < 64; i++) ms_v[s][i] = 1'b0;
        end
    endtask

    function automatic int hashf(int a, int b, int n);
        logic [31:0] p;
        p = 32'(a) * 32'h9E3779B1;
        return int'((p ^ 32'(b)) % 32'(n));
    endfunction

    // Result and latency in cycles (rsp_valid seen in cycle N after the
    // accepting edge, counting the cycle right after that edge as 1).
    task automatic model_req(input int s, input int a, input int b,
                             output int lit, output int hit, output int nw,
                             output int full, output int cyc);
        int l0, l1, h, slot, key;
        l0 = (a < b) ? a : b;
        l1 = (a < b) ? b : a;
        hit = 0; nw = 0; full = 0; lit = 0; cyc = 1;
        if (l0 == l1)            begin lit = l0; return; end
        if (l0 == (l1 ^ 1))      begin lit = 0;  return; end
        if (l0 == 0)             begin lit = 0;  return; end
        if (l0 == 1)             begin lit = l1; return; end
        key = l0 * 65536 + l1;
        h   = hashf(l0, l1, m_size[s]);
        for (int j = 0; j < m_size[s]; j++) begin
            slot = (h + j) % m_size[s];
            if (ms_v[s][slot] && ms_key[s][slot] == key) begin
                lit = ms_id[s][slot] * 2; hit = 1; cyc = 3 + j; return;
            end
            if (!ms_v[s][slot]) begin
                cyc = 4 + j;
                if (m_next[s] > 32767) begin full = 1; return; end
                ms_v[s][slot] = 1'b1; ms_key[s][slot] = key;
                ms_id[s][slot] = m_next[s]; lit = m_next[s] * 2; nw = 1;
                m_next[s]++;
                return;
            end
        end
        full = 1; cyc = m_size[s] + 2;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One full transaction; returns what the DUT actually produced.
    task automatic do_req(input int a, input int b, input int hold, input string tag,
                          output int o_lit, output int o_hit, output int o_new,
                          output int o_full, output int o_cyc);
        int n, e_lit, e_hit, e_new, e_full, e_cyc;
        logic [20:0] cap;
        n = 0;
        while (!m_rq && n < 50) begin @(posedge clk); #1; n++; end
        chk({tag, " req_ready"}, 32'(m_rq), 1);
        req_lit0 = 16'(a); req_lit1 = 16'(b); req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        model_req(sel, a, b, e_lit, e_hit, e_new, e_full, e_cyc);
        n = 0;
        while (!m_rv && n < 300) begin @(posedge clk); #1; n++; end
        o_cyc = n + 1;
        chk({tag, " latency"}, 32'(o_cyc), 32'(e_cyc));
        chk({tag, " lit"}, 32'(m_lit), 32'(e_lit));
        chk({tag, " hit/new/full"}, {29'd0, m_h, m_n, m_f},
            {29'd0, e_hit[0], e_new[0], e_full[0]});
        o_lit = int'(m_lit); o_hit = int'(m_h); o_new = int'(m_n); o_full = int'(m_f);
        cap = {m_rv, m_rq, m_lit, m_h, m_n, m_f};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, " hold stable"}, 32'({m_rv, m_rq, m_lit, m_h, m_n, m_f}),
                32'({1'b1, 1'b0, cap[18:0]}));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, " rsp_valid drop"}, 32'(m_rv), 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_clear();
        chk("clear req_ready", 32'(m_rq), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lit, hit, nw, full, cyc, n;
        logic seen;
        rst = 1'b1; clear = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_lit0 = '0; req_lit1 = '0; sel = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state of both instances
        chk("reset req_ready0", 32'(rq0), 1);
        chk("reset rsp0", {27'd0, rv0, h0, n0, f0, |lo0}, 0);
        chk("reset req_ready1", 32'(rq1), 1);
        chk("reset rsp1", {27'd0, rv1, h1, n1, f1, |lo1}, 0);

        // 1: duplicate a&b merged
        do_req(2, 4, 0, "t1 a&b", lit, hit, nw, full, cyc);
        chk("t1 pin new lit", 32'(lit), 8);
        chk("t1 pin new flag", 32'(nw), 1);
        do_req(4, 2, 0, "t1 b&a", lit, hit, nw, full, cyc);
        chk("t1 pin hit lit", 32'(lit), 8);
        chk("t1 pin hit flag", 32'(hit), 1);

        // 2: two gates, both looked up again in swapped order
        do_clear();
        do_req(2, 4, 0, "t2 a&b", lit, hit, nw, full, cyc);
        do_req(8, 6, 0, "t2 c&ab", lit, hit, nw, full, cyc);
        chk("t2 pin lit 10", 32'(lit), 10);
        do_req(4, 2, 0, "t2 b&a", lit, hit, nw, full, cyc);
        do_req(6, 8, 0, "t2 ab&c", lit, hit, nw, full, cyc);
        chk("t2 pin hit 10", 32'({lit[15:0], hit[0]}), 32'({16'd10, 1'b1}));
        do_req(2, 6, 0, "t2 next id", lit, hit, nw, full, cyc);
        chk("t2 pin next id 6", 32'(lit), 12);

        // 3: trivial requests
        do_req(2, 3, 0, "t3 x&~x", lit, hit, nw, full, cyc);
        chk("t3 pin x&~x", 32'({lit[15:0], cyc[3:0]}), 32'({16'd0, 4'd1}));
        do_req(2, 2, 0, "t3 x&x", lit, hit, nw, full, cyc);
        chk("t3 pin x&x", 32'(lit), 2);
        do_req(1, 6, 0, "t3 1&x", lit, hit, nw, full, cyc);
        chk("t3 pin 1&x", 32'({lit[15:0], hit[0], nw[0]}), 32'({16'd6, 2'b00}));
        do_req(0, 6, 3, "t3 0&x", lit, hit, nw, full, cyc);
        chk("t3 pin 0&x", 32'(lit), 0);

        // 4: four-entry table fills, fifth distinct pair reports full
        sel = 1;
        do_clear();
        do_req(2, 4, 0, "t4 p1", lit, hit, nw, full, cyc);
        chk("t4 pin id4", 32'(lit), 8);
        do_req(2, 6, 0, "t4 p2", lit, hit, nw, full, cyc);
        do_req(4, 6, 0, "t4 p3", lit, hit, nw, full, cyc);
        do_req(8, 10, 0, "t4 p4", lit, hit, nw, full, cyc);
        chk("t4 pin id7", 32'(lit), 14);
        do_req(12, 14, 0, "t4 p5", lit, hit, nw, full, cyc);
        chk("t4 pin full", 32'({lit[15:0], full[0], nw[0]}), 32'({16'd0, 2'b10}));
        do_req(8, 10, 0, "t4 rehit", lit, hit, nw, full, cyc);

        // 5: back-pressure and forced collision (2,4) vs (2,68) share a slot
        sel = 0;
        do_clear();
        do_req(2, 4, 0, "t5 home", lit, hit, nw, full, cyc);
        chk("t5 pin home cyc", 32'(cyc), 4);
        do_req(2, 68, 5, "t5 collide", lit, hit, nw, full, cyc);
        chk("t5 pin collide", 32'({lit[15:0], nw[0], cyc[7:0]}), 32'({16'd10, 1'b1, 8'd5}));
        do_req(68, 2, 2, "t5 rehit", lit, hit, nw, full, cyc);
        chk("t5 pin rehit", 32'({lit[15:0], hit[0], cyc[7:0]}), 32'({16'd10, 1'b1, 8'd4}));

        // 6: clear while probing drops the request
        do_clear();
        req_lit0 = 16'd2; req_lit1 = 16'd6; req_valid = 1'b1;
        @(posedge clk); #1;       // accepted, now hashing
        req_valid = 1'b0;
        @(posedge clk); #1;       // probing
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_clear();
        chk("t6 idle after clear", 32'({m_rq, m_rv}), 32'(2'b10));
        seen = 1'b0;
        for (n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            seen = seen | m_rv;
        end
        chk("t6 no response", 32'(seen), 0);
        do_req(2, 4, 0, "t6 after", lit, hit, nw, full, cyc);
        chk("t6 pin lit 8", 32'({lit[15:0], nw[0]}), 32'({16'd8, 1'b1}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
